// File: rtl/nco_bcd_scan_disp_if.sv
// Bus bundle for nco_bcd_scan_disp: counter/NCO controls in, counter state and display pins out.
interface nco_bcd_scan_disp_if #(
    parameter int unsigned NUM_DIG = 6,
    parameter int unsigned NCO_W   = 32
);
    logic [NCO_W-1:0]     i_nco_num;
    logic [1:0]           i_mode;
    logic                 i_load;
    logic [4*NUM_DIG-1:0] i_load_val;
    logic [NUM_DIG-1:0]   i_dp_sel;
    logic                 o_tick;
    logic                 o_wrap;
    logic [4*NUM_DIG-1:0] o_bcd;
    logic [6:0]           o_seg;
    logic                 o_seg_dp;
    logic [NUM_DIG-1:0]   o_seg_enb;

    modport master (
        output i_nco_num, i_mode, i_load, i_load_val, i_dp_sel,
        input  o_tick, o_wrap, o_bcd, o_seg, o_seg_dp, o_seg_enb
    );

    modport slave (
        input  i_nco_num, i_mode, i_load, i_load_val, i_dp_sel,
        output o_tick, o_wrap, o_bcd, o_seg, o_seg_dp, o_seg_enb
    );
endinterface

// File: rtl/nco_bcd_scan_disp.sv
// NCO-ticked loadable up/down BCD counter driving a multiplexed 7-segment scanner.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module nco_bcd_scan_disp #(
    parameter int unsigned NUM_DIG  = 6,
    parameter int unsigned NCO_W    = 32,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    nco_bcd_scan_disp_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIG);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_CLR  = 2'b11
    } mode_e;

    logic [NCO_W-1:0]     acc_q, acc_d;
    logic                 tick_q, tick_d;
    logic [4*NUM_DIG-1:0] bcd_q, bcd_d;
    logic                 wrap_q, wrap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [NUM_DIG-1:0]   enb_q, enb_d;
    logic [NUM_DIG-1:0]   lead_blank;
    mode_e                mode;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    assign mode = mode_e'(bus.i_mode);

    always_comb begin
        logic [NCO_W:0] sum;
        sum    = {1'b0, acc_q} + {1'b0, bus.i_nco_num};
        acc_d  = sum[NCO_W-1:0];
        tick_d = sum[NCO_W];
    end

    always_comb begin
        logic       carry;
        logic [3:0] dig;
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        carry  = 1'b1;
        dig    = 4'd0;
        if (bus.i_load) begin
            for (int unsigned k = 0; k < NUM_DIG; k++) begin
                dig = bus.i_load_val[4*k +: 4];
                bcd_d[4*k +: 4] = (dig > 4'd9) ? 4'd9 : dig;
            end
        end else if (mode == MODE_CLR) begin
            bcd_d = '0;
        end else if (tick_q && mode == MODE_UP) begin
            for (int unsigned k = 0; k < NUM_DIG; k++) begin
                dig = bcd_q[4*k +: 4];
                if (carry) begin
                    if (dig == 4'd9) begin
                        bcd_d[4*k +: 4] = 4'd0;
                    end else begin
                        bcd_d[4*k +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end else if (tick_q && mode == MODE_DOWN) begin
            // carry doubles as the ripple borrow here
            for (int unsigned k = 0; k < NUM_DIG; k++) begin
                dig = bcd_q[4*k +: 4];
                if (carry) begin
                    if (dig == 4'd0) begin
                        bcd_d[4*k +: 4] = 4'd9;
                    end else begin
                        bcd_d[4*k +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        lead_blank = '0;
`ifdef LEAD_ZERO_BLANK_EN
        begin
            logic nz_seen;
            nz_seen = 1'b0;
            for (int unsigned k = NUM_DIG - 1; k > 0; k--) begin
                nz_seen       = nz_seen | (bcd_q[4*k +: 4] != 4'd0);
                lead_blank[k] = ~nz_seen;
            end
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        seg_d = 7'h00;
        dp_d  = 1'b0;
        enb_d = '1;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                seg_d    = lead_blank[k] ? 7'h00 : seg_decode(bcd_q[4*k +: 4]);
                dp_d     = bus.i_dp_sel[k];
                enb_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
            bcd_q  <= '0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
            idx_q  <= '0;
            seg_q  <= 7'h00;
            dp_q   <= 1'b0;
            enb_q  <= '1;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
            bcd_q  <= bcd_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            enb_q  <= enb_d;
        end
    end

    assign bus.o_tick    = tick_q;
    assign bus.o_wrap    = wrap_q;
    assign bus.o_bcd     = bcd_q;
    assign bus.o_seg     = seg_q;
    assign bus.o_seg_dp  = dp_q;
    assign bus.o_seg_enb = enb_q;
endmodule

// File: tb/tb_nco_bcd_scan_disp.sv
// Directed bench for nco_bcd_scan_disp (NUM_DIG=6, NCO_W=32, SCAN_DIV=4).
// Honours LEAD_ZERO_BLANK_EN to pick the expected leading-digit pattern.
module tb_nco_bcd_scan_disp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    nco_bcd_scan_disp_if #(.NUM_DIG(6), .NCO_W(32)) bus ();

    nco_bcd_scan_disp #(.NUM_DIG(6), .NCO_W(32), .SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stops on the cycle where o_tick is visible, so the tick is consumed by the next edge.
    task automatic wait_tick();
        int n;
        n = 0;
        while (bus.o_tick !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check("tick_seen", {31'd0, bus.o_tick}, 32'd1);
    endtask

    task automatic load(input logic [23:0] val);
        bus.i_load     = 1'b1;
        bus.i_load_val = val;
        step();
        bus.i_load     = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0]  exp_seg [6];
        logic [5:0]  exp_enb [6];
        logic [6:0]  blank_seg;
`ifdef LEAD_ZERO_BLANK_EN
        blank_seg = 7'h00;
`else
        blank_seg = 7'h3F;
`endif
        exp_enb = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

        bus.i_nco_num  = 32'h4000_0000;
        bus.i_mode     = 2'b01;
        bus.i_load     = 1'b0;
        bus.i_load_val = '0;
        bus.i_dp_sel   = '0;
        step();
        step();
        check("rst_bcd", {8'd0, bus.o_bcd}, 32'h0);
        check("rst_enb", {26'd0, bus.o_seg_enb}, 32'h3F);
        check("rst_seg", {25'd0, bus.o_seg}, 32'h00);

        // NCO rate: carry on every 4th add, counter follows one edge later
        release_rst();
        for (int n = 1; n <= 41; n++) begin
            step();
            if (n <= 8) check("nco_tick", {31'd0, bus.o_tick}, (n % 4 == 0) ? 32'd1 : 32'd0);
        end
        check("nco_bcd_41", {8'd0, bus.o_bcd}, 32'h10);

        // Wrap up
        bus.i_mode = 2'b00;
        load(24'h999999);
        check("load_999999", {8'd0, bus.o_bcd}, 32'h999999);
        bus.i_mode = 2'b01;
        wait_tick();
        step();
        check("wrap_up_bcd", {8'd0, bus.o_bcd}, 32'h000000);
        check("wrap_up_pulse", {31'd0, bus.o_wrap}, 32'd1);
        bus.i_mode = 2'b00;
        step();
        check("wrap_up_clear", {31'd0, bus.o_wrap}, 32'd0);

        // Wrap down
        bus.i_mode = 2'b10;
        wait_tick();
        step();
        check("wrap_dn_bcd", {8'd0, bus.o_bcd}, 32'h999999);
        check("wrap_dn_pulse", {31'd0, bus.o_wrap}, 32'd1);
        bus.i_mode = 2'b00;
        step();
        check("wrap_dn_clear", {31'd0, bus.o_wrap}, 32'd0);

        // Load beats a coincident tick; clear gives no wrap
        bus.i_mode = 2'b01;
        wait_tick();
        load(24'h004567);
        check("prio_load", {8'd0, bus.o_bcd}, 32'h004567);
        bus.i_mode = 2'b11;
        step();
        check("clr_bcd", {8'd0, bus.o_bcd}, 32'h0);
        check("clr_wrap", {31'd0, bus.o_wrap}, 32'd0);
        bus.i_mode = 2'b00;

        // Ripple carry and borrow across digits
        load(24'h000199);
        bus.i_mode = 2'b01;
        wait_tick();
        step();
        check("carry_ripple", {8'd0, bus.o_bcd}, 32'h000200);
        check("carry_nowrap", {31'd0, bus.o_wrap}, 32'd0);
        bus.i_mode = 2'b00;
        load(24'h001000);
        bus.i_mode = 2'b10;
        wait_tick();
        step();
        check("borrow_ripple", {8'd0, bus.o_bcd}, 32'h000999);
        bus.i_mode = 2'b00;

        // Load saturation of non-BCD digits
        load(24'h0A0F03);
        check("load_sat", {8'd0, bus.o_bcd}, 32'h090903);

        // Zero increment never ticks
        bus.i_nco_num = 32'h0;
        step();
        step();
        load(24'h000321);
        bus.i_mode = 2'b01;
        for (int n = 0; n < 12; n++) begin
            step();
            if (n % 4 == 0) check("nco_zero_tick", {31'd0, bus.o_tick}, 32'd0);
        end
        check("nco_zero_hold", {8'd0, bus.o_bcd}, 32'h000321);

        // Asynchronous reset mid-count
        bus.i_mode = 2'b00;
        load(24'h000123);
        check("pre_rst_bcd", {8'd0, bus.o_bcd}, 32'h000123);
        #2 rst = 1'b1;
        #1;
        check("arst_bcd", {8'd0, bus.o_bcd}, 32'h0);
        check("arst_enb", {26'd0, bus.o_seg_enb}, 32'h3F);
        check("arst_seg", {25'd0, bus.o_seg}, 32'h00);
        check("arst_dp", {31'd0, bus.o_seg_dp}, 32'd0);
        check("arst_tick", {31'd0, bus.o_tick}, 32'd0);
        check("arst_wrap", {31'd0, bus.o_wrap}, 32'd0);

        // Scan of 123456: digit k is presented after edges 4k+1..4k+4
        exp_seg = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        bus.i_load     = 1'b1;
        bus.i_load_val = 24'h123456;
        bus.i_dp_sel   = 6'b000100;
        release_rst();
        for (int n = 1; n <= 24; n++) begin
            step();
            bus.i_load = 1'b0;
            if (n % 4 == 3) begin
                check("scan_enb", {26'd0, bus.o_seg_enb}, {26'd0, exp_enb[n/4]});
                check("scan_seg", {25'd0, bus.o_seg}, {25'd0, exp_seg[n/4]});
                check("scan_dp", {31'd0, bus.o_seg_dp}, (n/4 == 2) ? 32'd1 : 32'd0);
            end
        end

        // Leading-zero handling for 000070
        rst = 1'b1;
        #1;
        exp_seg = '{7'h3F, 7'h07, blank_seg, blank_seg, blank_seg, blank_seg};
        bus.i_load     = 1'b1;
        bus.i_load_val = 24'h000070;
        bus.i_dp_sel   = 6'b000000;
        release_rst();
        for (int n = 1; n <= 24; n++) begin
            step();
            bus.i_load = 1'b0;
            if (n % 4 == 3) begin
                check("blank_enb", {26'd0, bus.o_seg_enb}, {26'd0, exp_enb[n/4]});
                check("blank_seg", {25'd0, bus.o_seg}, {25'd0, exp_seg[n/4]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
